// File: rtl/boton_pulsos.sv
// Front-panel button conditioner: per-channel debounce, then one-cycle press pulses.
// btup/btdown add hold-to-repeat and are silenced while both are held.
module boton_pulsos #(
    parameter int unsigned DEB_CYCLES    = 500000,
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 10000000,
    parameter int unsigned CNT_W         = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic cambiarfuncion,
    input  logic cambiarsalida,
    input  logic btup,
    input  logic btdown,
    output logic pcambiarfuncion,
    output logic pcambiarsalida,
    output logic pbtup,
    output logic pbtdown
);

    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rep_state_e;

    // Channel order: 0 cambiarfuncion, 1 cambiarsalida, 2 btup, 3 btdown
    logic [3:0]       raw;
    logic [3:0]       st_q, st_d, rise;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    assign raw = {btdown, btup, cambiarsalida, cambiarfuncion};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = '0;
            if (raw[i] != st_q[i]) begin
                if (cnt_q[i] == DEB_LAST) begin
                    st_d[i] = raw[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Rise is taken from the next debounced state so the pulse lands with the transition
    assign rise = st_d & ~st_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q            <= '0;
            pcambiarfuncion <= 1'b0;
            pcambiarsalida  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            st_q            <= st_d;
            pcambiarfuncion <= rise[0];
            pcambiarsalida  <= rise[1];
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    logic [1:0]       rep_st, rep_rise, prep_q;
    logic             both_held;
    rep_state_e       state_q [2];
    logic [CNT_W-1:0] tmr_q [2];

    assign rep_st    = st_d[3:2];
    assign rep_rise  = rise[3:2];
    assign both_held = rep_st[0] & rep_st[1];

    // Repeat FSMs for btup (0) and btdown (1); both held forces idle until a fresh press
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                state_q[i] <= StIdle;
                tmr_q[i]   <= '0;
                prep_q[i]  <= 1'b0;
            end else begin
                prep_q[i] <= 1'b0;
                if (both_held) begin
                    state_q[i] <= StIdle;
                    tmr_q[i]   <= '0;
                end else begin
                    case (state_q[i])
                        StIdle: begin
                            if (rep_rise[i]) begin
                                prep_q[i]  <= 1'b1;
                                state_q[i] <= StDelay;
                                tmr_q[i]   <= '0;
                            end
                        end
                        StDelay: begin
                            if (!rep_st[i]) begin
                                state_q[i] <= StIdle;
                            end else if (tmr_q[i] == DELAY_LAST) begin
                                prep_q[i]  <= 1'b1;
                                state_q[i] <= StRepeat;
                                tmr_q[i]   <= '0;
                            end else begin
                                tmr_q[i] <= tmr_q[i] + CNT_W'(1);
                            end
                        end
                        StRepeat: begin
                            if (!rep_st[i]) begin
                                state_q[i] <= StIdle;
                            end else if (tmr_q[i] == PERIOD_LAST) begin
                                prep_q[i] <= 1'b1;
                                tmr_q[i]  <= '0;
                            end else begin
                                tmr_q[i] <= tmr_q[i] + CNT_W'(1);
                            end
                        end
                        default: state_q[i] <= StIdle;
                    endcase
                end
            end
        end
    end

    assign pbtup   = prep_q[0];
    assign pbtdown = prep_q[1];

endmodule
